// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: debounced push-button to single-cycle toggle-enable pulse generator with auto-repeat
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   btn_in      - raw asynchronous button level, 1 = pressed
//   repeat_en   - enables auto-repeat pulses while the button is held
//   t           - registered toggle-enable pulse, one clk period wide
//   pressed     - debounced button level
//   press_count - number of t pulses issued, wraps silently
module toggle_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             repeat_en,
    output logic             t,
    output logic             pressed,
    output logic [CNT_W-1:0] press_count
);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;
    logic [DW-1:0]          dcnt, dcnt_n;
    logic [RW-1:0]          rcnt, rcnt_n;
    logic                   pulse;
    logic                   d_done, rd_done, rr_done;

    assign btn_s   = sync[SYNC_STAGES-1];
    assign d_done  = dcnt == DW'(DEBOUNCE_CYCLES);
    assign rd_done = rcnt == RW'(REPEAT_DELAY);
    assign rr_done = rcnt == RW'(REPEAT_RATE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync        <= '0;
            state       <= IDLE;
            dcnt        <= '0;
            rcnt        <= '0;
            t           <= 1'b0;
            press_count <= '0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], btn_in};
            state       <= state_n;
            dcnt        <= dcnt_n;
            rcnt        <= rcnt_n;
            t           <= pulse;
            press_count <= pulse ? press_count + CNT_W'(1) : press_count;
        end
    end

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        rcnt_n  = rcnt;
        case (state)
            IDLE: begin
                state_n = btn_s ? DB_PRESS : IDLE;
                dcnt_n  = btn_s ? DW'(1) : '0;
                rcnt_n  = '0;
            end
            DB_PRESS: begin
                state_n = !btn_s ? IDLE : d_done ? HELD : DB_PRESS;
                dcnt_n  = !btn_s ? '0 : d_done ? dcnt : dcnt + DW'(1);
                rcnt_n  = '0;
            end
            HELD: begin
                state_n = !btn_s ? DB_RELEASE : (repeat_en && rd_done) ? REPEAT : HELD;
                dcnt_n  = !btn_s ? DW'(1) : dcnt;
                rcnt_n  = (!btn_s || !repeat_en || rd_done) ? '0 : rcnt + RW'(1);
            end
            REPEAT: begin
                state_n = !btn_s ? DB_RELEASE : !repeat_en ? HELD : REPEAT;
                dcnt_n  = !btn_s ? DW'(1) : dcnt;
                rcnt_n  = (!btn_s || !repeat_en || rr_done) ? '0 : rcnt + RW'(1);
            end
            DB_RELEASE: begin
                // a re-press before the release is accepted counts as a glitch, not a new press
                state_n = btn_s ? HELD : d_done ? IDLE : DB_RELEASE;
                dcnt_n  = btn_s ? dcnt : d_done ? '0 : dcnt + DW'(1);
                rcnt_n  = '0;
            end
            default: begin
                state_n = IDLE;
                dcnt_n  = '0;
                rcnt_n  = '0;
            end
        endcase
    end

    always_comb begin
        pulse   = btn_s && ((state == DB_PRESS && d_done) ||
                  (repeat_en && ((state == HELD && rd_done) || (state == REPEAT && rr_done))));
        pressed = state == HELD || state == REPEAT || state == DB_RELEASE;
    end
endmodule
